// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared timing constants and types for the VGA sync generator.
//   - DEF_* : default 640x480@60 timing (800x525 total).
//   - COUNT_W : width of the column/row counters.
//   - axis_state_t : per-axis phase (ACTIVE/FRONT/SYNC/BACK).
//   - axis_state_of() : phase of a given position on one axis.
//   - axis_timing_legal() : parameter sanity check used at elaboration.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int unsigned DEF_TOTAL_COLS    = 800;
    localparam int unsigned DEF_TOTAL_ROWS    = 525;
    localparam int unsigned DEF_ACTIVE_COLS   = 640;
    localparam int unsigned DEF_ACTIVE_ROWS   = 480;
    localparam int unsigned DEF_H_FRONT_PORCH = 16;
    localparam int unsigned DEF_H_SYNC_WIDTH  = 96;
    localparam int unsigned DEF_V_FRONT_PORCH = 10;
    localparam int unsigned DEF_V_SYNC_WIDTH  = 2;

    localparam int unsigned COUNT_W = 10;

    typedef enum logic [1:0] {
        AXIS_ACTIVE = 2'd0,
        AXIS_FRONT  = 2'd1,
        AXIS_SYNC   = 2'd2,
        AXIS_BACK   = 2'd3
    } axis_state_t;

    // Phase of a position on one axis. Zero-length porches simply drop out.
    function automatic axis_state_t axis_state_of(
        input logic [COUNT_W-1:0] pos,
        input int unsigned        active,
        input int unsigned        front,
        input int unsigned        sync_w
    );
        int unsigned p;
        axis_state_t result;
        p = 32'(pos);
        if (p < active) begin
            result = AXIS_ACTIVE;
        end else if (p < active + front) begin
            result = AXIS_FRONT;
        end else if (p < active + front + sync_w) begin
            result = AXIS_SYNC;
        end else begin
            result = AXIS_BACK;
        end
        return result;
    endfunction

    // The back porch must be at least one unit long, and the period must
    // fit in the counter.
    function automatic bit axis_timing_legal(
        input int unsigned total,
        input int unsigned active,
        input int unsigned front,
        input int unsigned sync_w
    );
        return (active + front + sync_w < total) && (total <= (1 << COUNT_W));
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// ---------------------------------------------------------------------------
// vga_axis_timer
//   One axis (horizontal or vertical) of the VGA timing: position counter,
//   phase FSM and active-low sync output.
//   Ports:
//     clk        - pixel clock, rising edge
//     reset      - synchronous, active-high
//     step       - advance the position by one this cycle
//     count      - registered position, 0..TOTAL-1
//     next_state - phase the axis enters on the coming edge
//     sync       - registered sync, low while the phase is SYNC
//     wrap       - high when this step takes the position TOTAL-1 -> 0
// ---------------------------------------------------------------------------
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL  = DEF_TOTAL_COLS,
    parameter int unsigned ACTIVE = DEF_ACTIVE_COLS,
    parameter int unsigned FRONT  = DEF_H_FRONT_PORCH,
    parameter int unsigned SYNC_W = DEF_H_SYNC_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step,
    output logic [COUNT_W-1:0] count,
    output axis_state_t        next_state,
    output logic               sync,
    output logic               wrap
);

    if (!axis_timing_legal(TOTAL, ACTIVE, FRONT, SYNC_W)) begin : g_illegal_timing
        $error("vga_axis_timer: ACTIVE+FRONT+SYNC must be below TOTAL and TOTAL must fit the counter");
    end

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);

    axis_state_t        state;
    logic [COUNT_W-1:0] count_next;

    // Next-state logic: the phase is decoded from the position being entered,
    // so state, count and sync always describe the same position.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        count_next = count;
        next_state = state;
        wrap       = 1'b0;
        if (step) begin
            if (count == LAST) begin
                count_next = '0;
                wrap       = 1'b1;
            end else begin
                count_next = count + 1'b1;
            end
            next_state = axis_state_of(count_next, ACTIVE, FRONT, SYNC_W);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (reset) begin
            count <= '0;
            state <= AXIS_ACTIVE;
            sync  <= 1'b1;
        end else begin
            count <= count_next;
            state <= next_state;
            sync  <= (next_state != AXIS_SYNC);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//   VGA timing generator: horizontal and vertical axis timers plus the
//   registered active/line-start/frame-start/frame-count outputs.
//   Ports:
//     i_Clk         - pixel clock, rising edge
//     i_Reset       - synchronous, active-high; wins over i_Enable
//     i_Enable      - advance one pixel per cycle when high, freeze when low
//     o_HSync       - horizontal sync, active-low
//     o_VSync       - vertical sync, active-low
//     o_Col_Count   - current column, 0..c_TOTAL_COLS-1
//     o_Row_Count   - current row, 0..c_TOTAL_ROWS-1
//     o_Active      - current pixel is in the visible area
//     o_Line_Start  - pulse at column 0
//     o_Frame_Start - pulse at (0,0)
//     o_Frame_Count - completed frames, wraps 255 -> 0
//   All outputs are registered and describe the same pixel.
// ---------------------------------------------------------------------------
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned c_TOTAL_COLS    = DEF_TOTAL_COLS,
    parameter int unsigned c_TOTAL_ROWS    = DEF_TOTAL_ROWS,
    parameter int unsigned c_ACTIVE_COLS   = DEF_ACTIVE_COLS,
    parameter int unsigned c_ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
    parameter int unsigned c_H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int unsigned c_H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int unsigned c_V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int unsigned c_V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Enable,
    output logic               o_HSync,
    output logic               o_VSync,
    output logic [COUNT_W-1:0] o_Col_Count,
    output logic [COUNT_W-1:0] o_Row_Count,
    output logic               o_Active,
    output logic               o_Line_Start,
    output logic               o_Frame_Start,
    output logic [7:0]         o_Frame_Count
);

    axis_state_t h_next;
    axis_state_t v_next;
    logic        h_wrap;
    logic        v_wrap;

    vga_axis_timer #(
        .TOTAL  (c_TOTAL_COLS),
        .ACTIVE (c_ACTIVE_COLS),
        .FRONT  (c_H_FRONT_PORCH),
        .SYNC_W (c_H_SYNC_WIDTH)
    ) u_h_timer (
        .clk        (i_Clk),
        .reset      (i_Reset),
        .step       (i_Enable),
        .count      (o_Col_Count),
        .next_state (h_next),
        .sync       (o_HSync),
        .wrap       (h_wrap)
    );

    // The vertical axis steps once per line, on the column wrap.
    vga_axis_timer #(
        .TOTAL  (c_TOTAL_ROWS),
        .ACTIVE (c_ACTIVE_ROWS),
        .FRONT  (c_V_FRONT_PORCH),
        .SYNC_W (c_V_SYNC_WIDTH)
    ) u_v_timer (
        .clk        (i_Clk),
        .reset      (i_Reset),
        .step       (h_wrap),
        .count      (o_Row_Count),
        .next_state (v_next),
        .sync       (o_VSync),
        .wrap       (v_wrap)
    );

    // Flags are computed from the position being entered so they line up
    // with the registered counters. h_wrap/v_wrap already include i_Enable.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Active      <= 1'b1;
            o_Line_Start  <= 1'b1;
            o_Frame_Start <= 1'b1;
            o_Frame_Count <= 8'd0;
        end else if (i_Enable) begin
            o_Active      <= (h_next == AXIS_ACTIVE) && (v_next == AXIS_ACTIVE);
            o_Line_Start  <= h_wrap;
            o_Frame_Start <= v_wrap;
            if (v_wrap) begin
                o_Frame_Count <= o_Frame_Count + 8'd1;
            end
        end else begin
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//   Two instances share clock, reset and enable: dut_d with default 800x525
//   timing and dut_s with a small 16x10 geometry so whole frames (and the
//   frame-count wrap) are reachable quickly. A pixel-index reference model
//   runs alongside both.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

    // Small geometry: hsync cols 12..14, vsync rows 7..8.
    localparam int S_TC = 16, S_TR = 10, S_AC = 10, S_AR = 6;
    localparam int S_HFP = 2, S_HSW = 3, S_VFP = 1, S_VSW = 2;
    localparam int S_FRAME = S_TC * S_TR;

    typedef struct {
        int tc, tr, ac, ar, hfp, hsw, vfp, vsw;
    } geom_t;

    typedef struct {
        int p;    // linear pixel index within the frame
        int fc;
        bit ls;
        bit fs;
    } mstate_t;

    typedef struct {
        bit r, e;
        int col, row;
        bit hs, vs, act, ls, fs;
        int fc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       d_hs, d_vs, d_act, d_ls, d_fs;
    logic [9:0] d_col, d_row;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_act, s_ls, s_fs;
    logic [9:0] s_col, s_row;
    logic [7:0] s_fc;
    logic [32:0] d_vec, s_vec;

    assign d_vec = {d_col, d_row, d_hs, d_vs, d_act, d_ls, d_fs, d_fc};
    assign s_vec = {s_col, s_row, s_hs, s_vs, s_act, s_ls, s_fs, s_fc};

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(d_hs), .o_VSync(d_vs), .o_Col_Count(d_col), .o_Row_Count(d_row),
        .o_Active(d_act), .o_Line_Start(d_ls), .o_Frame_Start(d_fs), .o_Frame_Count(d_fc)
    );

    vga_sync_gen #(
        .c_TOTAL_COLS(S_TC), .c_TOTAL_ROWS(S_TR), .c_ACTIVE_COLS(S_AC), .c_ACTIVE_ROWS(S_AR),
        .c_H_FRONT_PORCH(S_HFP), .c_H_SYNC_WIDTH(S_HSW),
        .c_V_FRONT_PORCH(S_VFP), .c_V_SYNC_WIDTH(S_VSW)
    ) dut_s (
        .i_Clk(clk), .i_Reset(rst), .i_Enable(en),
        .o_HSync(s_hs), .o_VSync(s_vs), .o_Col_Count(s_col), .o_Row_Count(s_row),
        .o_Active(s_act), .o_Line_Start(s_ls), .o_Frame_Start(s_fs), .o_Frame_Count(s_fc)
    );

    int total = 0;
    int bad   = 0;

    geom_t   g_def, g_sml;
    mstate_t md, ms;
    bit      model_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one pixel index per enabled cycle, frame = tc*tr pixels.
    function automatic mstate_t model_step(input geom_t g, input mstate_t s, input bit r, input bit e);
        mstate_t n;
        n = s;
        if (r) begin
            n.p = 0; n.fc = 0; n.ls = 1'b1; n.fs = 1'b1;
        end else if (e) begin
            n.p  = (s.p + 1) % (g.tc * g.tr);
            if (n.p == 0) n.fc = (s.fc + 1) % 256;
            n.ls = (n.p % g.tc) == 0;
            n.fs = (n.p == 0);
        end else begin
            n.ls = 1'b0; n.fs = 1'b0;
        end
        return n;
    endfunction

    function automatic logic [32:0] model_out(input geom_t g, input mstate_t s);
        int c, r;
        bit hs, vs, act;
        c   = s.p % g.tc;
        r   = s.p / g.tc;
        hs  = !(c >= g.ac + g.hfp && c < g.ac + g.hfp + g.hsw);
        vs  = !(r >= g.ar + g.vfp && r < g.ar + g.vfp + g.vsw);
        act = (c < g.ac) && (r < g.ar);
        return {10'(c), 10'(r), hs, vs, act, s.ls, s.fs, 8'(s.fc)};
    endfunction

    function automatic logic [32:0] pack_vec(input vec_t v);
        return {10'(v.col), 10'(v.row), v.hs, v.vs, v.act, v.ls, v.fs, 8'(v.fc)};
    endfunction

    // One clock: drive inputs, wait for the edge, sample 1 time unit later.
    task automatic cyc(input bit r, input bit e);
        rst = r;
        en  = e;
        @(posedge clk);
        #1;
        md = model_step(g_def, md, r, e);
        ms = model_step(g_sml, ms, r, e);
        if (r) model_on = 1'b1;
        if (model_on) begin
            check("model_def", 64'(d_vec), 64'(model_out(g_def, md)));
            check("model_sml", 64'(s_vec), 64'(model_out(g_sml, ms)));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1);
    endtask

    vec_t tbl[9];

    initial begin
        int hs_low, hs_first, hs_last, ls_off, frz, cnt_vs, cnt_fs, cnt_act;
        logic [32:0] snap;

        g_def = '{800, 525, 640, 480, 16, 96, 10, 2};
        g_sml = '{S_TC, S_TR, S_AC, S_AR, S_HFP, S_HSW, S_VFP, S_VSW};
        md = '{0, 0, 1'b0, 1'b0};
        ms = '{0, 0, 1'b0, 1'b0};

        //        r  e  col row hs vs act ls fs fc
        tbl[0] = '{1, 0, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[1] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0};  // reset beats enable
        tbl[2] = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};  // frozen, pulses drop
        tbl[3] = '{0, 1, 1, 0, 1, 1, 1, 0, 0, 0};
        tbl[4] = '{0, 1, 2, 0, 1, 1, 1, 0, 0, 0};
        tbl[5] = '{0, 0, 2, 0, 1, 1, 1, 0, 0, 0};
        tbl[6] = '{0, 1, 3, 0, 1, 1, 1, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        tbl[8] = '{0, 1, 1, 0, 1, 1, 1, 0, 0, 0};  // first enabled cycle after reset

        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].r, tbl[i].e);
            check($sformatf("table_%0d", i), 64'(d_vec), 64'(pack_vec(tbl[i])));
        end

        // One full line at default timing.
        cyc(1'b1, 1'b0);
        hs_low = 0; hs_first = -1; hs_last = -1; ls_off = 0;
        for (int i = 1; i <= 800; i++) begin
            cyc(1'b0, 1'b1);
            if (!d_hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_col);
                hs_last = int'(d_col);
            end
            if (d_ls && d_col != 10'd0) ls_off++;
        end
        check("line_hs_low_cycles", 64'(hs_low), 64'd96);
        check("line_hs_first_col", 64'(hs_first), 64'd656);
        check("line_hs_last_col", 64'(hs_last), 64'd751);
        check("line_ls_off_col0", 64'(ls_off), 64'd0);
        check("line_row_after_800", 64'({d_row, d_col, d_ls}), 64'({10'd1, 10'd0, 1'b1}));

        // Freeze for 37 cycles at col 655.
        cyc(1'b1, 1'b0);
        run(655);
        check("freeze_start_pos", 64'({d_col, d_hs}), 64'({10'd655, 1'b1}));
        snap = d_vec;
        frz = 0;
        for (int i = 0; i < 37; i++) begin
            cyc(1'b0, 1'b0);
            if (d_vec !== snap) frz++;
        end
        check("freeze_held", 64'(frz), 64'd0);
        cyc(1'b0, 1'b1);
        check("freeze_resume", 64'({d_col, d_row, d_hs}), 64'({10'd656, 10'd0, 1'b0}));

        // Whole frame on the small geometry.
        cyc(1'b1, 1'b0);
        cnt_vs = 0; cnt_fs = 0; cnt_act = 0;
        for (int i = 0; i < S_FRAME; i++) begin
            cyc(1'b0, 1'b1);
            if (!s_vs) cnt_vs++;
            if (s_fs) cnt_fs++;
            if (s_act) cnt_act++;
        end
        check("frame_vs_low_cycles", 64'(cnt_vs), 64'(S_VSW * S_TC));
        check("frame_fs_count", 64'(cnt_fs), 64'd1);
        check("frame_active_cycles", 64'(cnt_act), 64'(S_AC * S_AR));
        check("frame_end_state", 64'({s_col, s_row, s_fc}), 64'({10'd0, 10'd0, 8'd1}));

        // Reset mid-frame while both syncs are low.
        cyc(1'b1, 1'b0);
        run(2 * S_FRAME + 7 * S_TC + 13);
        check("midreset_before", 64'({s_col, s_row, s_hs, s_vs, s_fc}),
              64'({10'd13, 10'd7, 1'b0, 1'b0, 8'd2}));
        cyc(1'b1, 1'b0);
        check("midreset_after", 64'({s_col, s_row, s_hs, s_vs, s_fc}),
              64'({10'd0, 10'd0, 1'b1, 1'b1, 8'd0}));

        // Reset and enable together: position must not advance.
        run(3);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1);
            check("rst_en_hold", 64'({d_col, d_row, d_ls, s_col, s_row}), 64'd0 | 64'({10'd0, 10'd0, 1'b1, 10'd0, 10'd0}));
        end

        // 256 frames: frame count wraps 255 -> 0 with frame start.
        cyc(1'b1, 1'b0);
        run(255 * S_FRAME - 1);
        check("wrap_pre_255", 64'({s_fc, s_fs}), 64'({8'd254, 1'b0}));
        cyc(1'b0, 1'b1);
        check("wrap_at_255", 64'({s_fc, s_fs}), 64'({8'd255, 1'b1}));
        run(S_FRAME - 1);
        check("wrap_last_pixel", 64'({s_fc, s_fs, s_col, s_row}),
              64'({8'd255, 1'b0, 10'(S_TC - 1), 10'(S_TR - 1)}));
        cyc(1'b0, 1'b1);
        check("wrap_to_0", 64'({s_fc, s_fs}), 64'({8'd0, 1'b1}));

        // Random enable / occasional reset against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
